// File: rtl/serial_lock_pkg.sv
// serial_lock_pkg: shared types and helpers for the serial password checker.
`default_nettype none

package serial_lock_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ENTER  = 3'd1,
      S_OPEN   = 3'd2,
      S_PROG   = 3'd3,
      S_LOCKED = 3'd4
   } lock_state_t;

   localparam int DIGIT_W_DEF = 4;
   typedef logic [DIGIT_W_DEF-1:0] digit_t;

   localparam int DIGITS_MAX = 8;
   localparam int POS_W_MAX  = $clog2(DIGITS_MAX + 1);

   // Unused upper flag bits are padded with ones by the caller.
   function automatic logic all_match(input logic [DIGITS_MAX-1:0] flags);
      return &flags;
   endfunction

endpackage

`default_nettype wire

// File: rtl/password_store.sv
// password_store: active user password plus a shadow that collects a new one;
// the shadow is copied into the active password only on commit.
`default_nettype none

module password_store #(
   parameter int                         DIGITS  = 4,
   parameter int                         DIGIT_W = 4,
   parameter int                         POS_W   = 3,
   parameter logic [DIGITS*DIGIT_W-1:0]  INIT    = '0
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               wr_en_i,
   input  logic [POS_W-1:0]   wr_idx_i,
   input  logic [DIGIT_W-1:0] wr_digit_i,
   input  logic               commit_i,
   input  logic               abort_i,
   input  logic [POS_W-1:0]   rd_idx_i,
   output logic [DIGIT_W-1:0] rd_digit_o
);

   localparam int PW_W = DIGITS * DIGIT_W;

   logic [PW_W-1:0] active_q;
   logic [PW_W-1:0] shadow_q;
   logic [PW_W-1:0] shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (wr_en_i && (POS_W'(i) == wr_idx_i)) begin
            shadow_d[i*DIGIT_W +: DIGIT_W] = wr_digit_i;
         end
      end
   end

   always_comb begin
      rd_digit_o = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (POS_W'(i) == rd_idx_i) begin
            rd_digit_o = active_q[i*DIGIT_W +: DIGIT_W];
         end
      end
   end

   // Commit takes the shadow including the final digit written this cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         active_q <= INIT;
         shadow_q <= INIT;
      end else if (abort_i) begin
         shadow_q <= active_q;
      end else begin
         shadow_q <= shadow_d;
         if (commit_i) begin
            active_q <= shadow_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/serial_password_checker.sv
// serial_password_checker: serial user/admin password lock with fail lockdown.
// Optional macro LOCK_TIMEOUT_EN adds automatic lockdown release after LOCK_CYCLES.
`default_nettype none

module serial_password_checker
   import serial_lock_pkg::*;
#(
   parameter int                         DIGITS      = 4,
   parameter int                         DIGIT_W     = DIGIT_W_DEF,
   parameter int                         MAX_FAIL    = 3,
   parameter logic [DIGITS*DIGIT_W-1:0]  USER_INIT   = '0,
   parameter logic [DIGITS*DIGIT_W-1:0]  ADMIN_CODE  = '0,
   parameter int                         LOCK_CYCLES = 1000,
   localparam int                        POS_W       = $clog2(DIGITS + 1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               enable,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               clear,
   input  logic               set_mode,
   input  logic               reset_lockdown,
   output logic [POS_W-1:0]   position,
   output logic               error_light,
   output logic               unlock_light,
   output logic               prog_light,
   output logic               lockdown,
   output logic [3:0]         fail_count
);

   lock_state_t        state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [3:0]         fail_q, fail_d;
   logic               err_q, err_d;
   logic               unlock_q, prog_q, lock_q;
   logic [DIGITS-1:0]  umatch_q, umatch_d, amatch_q, amatch_d;
   logic [DIGITS-1:0]  w_umatch, w_amatch;
   logic [DIGITS_MAX-1:0] w_upad, w_apad;
   logic [DIGIT_W-1:0] w_user_digit, w_admin_digit;
   logic               w_last, w_user_ok, w_admin_ok, w_timeout;
   logic               w_wr_en, w_commit, w_abort;

   password_store #(
      .DIGITS  (DIGITS),
      .DIGIT_W (DIGIT_W),
      .POS_W   (POS_W),
      .INIT    (USER_INIT)
   ) u_store (
      .clk_i      (CLK),
      .rst_n_i    (RST),
      .wr_en_i    (w_wr_en),
      .wr_idx_i   (pos_q),
      .wr_digit_i (digit),
      .commit_i   (w_commit),
      .abort_i    (w_abort),
      .rd_idx_i   (pos_q),
      .rd_digit_o (w_user_digit)
   );

   // Match flags include the digit arriving now, so the verdict lands on the last strobe.
   always_comb begin
      w_admin_digit = '0;
      w_umatch      = umatch_q;
      w_amatch      = amatch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (POS_W'(i) == pos_q) begin
            w_admin_digit = ADMIN_CODE[i*DIGIT_W +: DIGIT_W];
         end
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (POS_W'(i) == pos_q) begin
            w_umatch[i] = (digit == w_user_digit);
            w_amatch[i] = (digit == w_admin_digit);
         end
      end
      w_upad             = '1;
      w_apad             = '1;
      w_upad[DIGITS-1:0] = w_umatch;
      w_apad[DIGITS-1:0] = w_amatch;
      w_user_ok          = all_match(w_upad);
      w_admin_ok         = all_match(w_apad);
      w_last             = (pos_q == POS_W'(DIGITS - 1));
   end

`ifdef LOCK_TIMEOUT_EN
   localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
   logic [LCK_W-1:0] lock_cnt_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lock_cnt_q <= '0;
      end else if ((state_q == S_LOCKED) && (state_d == S_LOCKED)) begin
         lock_cnt_q <= lock_cnt_q + 1'b1;
      end else begin
         lock_cnt_q <= '0;
      end
   end

   assign w_timeout = (state_q == S_LOCKED) && (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1));
`else
   logic w_unused_lock_cycles;
   assign w_unused_lock_cycles = (LOCK_CYCLES != 0);
   assign w_timeout            = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      fail_d   = fail_q;
      err_d    = 1'b0;
      umatch_d = umatch_q;
      amatch_d = amatch_q;
      w_wr_en  = 1'b0;
      w_commit = 1'b0;
      w_abort  = 1'b0;
      case (state_q)
         S_IDLE, S_ENTER: begin
            if (reset_lockdown) fail_d = '0;
            if (clear) begin
               pos_d   = '0;
               state_d = S_IDLE;
            end else if (enable) begin
               umatch_d = w_umatch;
               amatch_d = w_amatch;
               if (w_last) begin
                  pos_d = '0;
                  if (w_admin_ok || w_user_ok) begin
                     state_d = S_OPEN;
                     fail_d  = '0;
                  end else begin
                     err_d   = 1'b1;
                     fail_d  = fail_d + 4'd1;
                     state_d = (fail_d == 4'(MAX_FAIL)) ? S_LOCKED : S_IDLE;
                  end
               end else begin
                  pos_d   = pos_q + 1'b1;
                  state_d = S_ENTER;
               end
            end
         end
         S_OPEN: begin
            if (reset_lockdown) fail_d = '0;
            if (clear) begin
               state_d = S_IDLE;
            end else if (set_mode) begin
               state_d = S_PROG;
               pos_d   = '0;
            end
         end
         S_PROG: begin
            if (reset_lockdown) fail_d = '0;
            if (clear) begin
               w_abort = 1'b1;
               pos_d   = '0;
               state_d = S_IDLE;
            end else if (enable) begin
               w_wr_en = 1'b1;
               if (w_last) begin
                  w_commit = 1'b1;
                  pos_d    = '0;
                  state_d  = S_IDLE;
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
         end
         S_LOCKED: begin
            if (reset_lockdown || w_timeout) begin
               state_d = S_IDLE;
               fail_d  = '0;
               pos_d   = '0;
            end else if (clear) begin
               pos_d = '0;
            end else if (enable) begin
               umatch_d = w_umatch;
               amatch_d = w_amatch;
               if (w_last) begin
                  pos_d = '0;
                  if (w_admin_ok) begin
                     state_d = S_OPEN;
                     fail_d  = '0;
                  end
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            pos_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         pos_q    <= '0;
         fail_q   <= '0;
         err_q    <= 1'b0;
         unlock_q <= 1'b0;
         prog_q   <= 1'b0;
         lock_q   <= 1'b0;
         umatch_q <= '0;
         amatch_q <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         fail_q   <= fail_d;
         err_q    <= err_d;
         unlock_q <= (state_d == S_OPEN);
         prog_q   <= (state_d == S_PROG);
         lock_q   <= (state_d == S_LOCKED);
         umatch_q <= umatch_d;
         amatch_q <= amatch_d;
      end
   end

   assign position     = pos_q;
   assign error_light  = err_q;
   assign unlock_light = unlock_q;
   assign prog_light   = prog_q;
   assign lockdown     = lock_q;
   assign fail_count   = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_password_checker.sv
// tb_serial_password_checker: directed vectors against a queue-based lock model.
`default_nettype none

module tb_serial_password_checker;

   localparam int DIGITS      = 4;
   localparam int DIGIT_W     = 4;
   localparam int MAX_FAIL    = 3;
   localparam int LOCK_CYCLES = 10;
   localparam logic [15:0] USER_INIT  = 16'h4321;
   localparam logic [15:0] ADMIN_CODE = 16'h9999;

   logic       CLK, RST, enable, clear, set_mode, reset_lockdown;
   logic [3:0] digit;
   logic [2:0] position;
   logic       error_light, unlock_light, prog_light, lockdown;
   logic [3:0] fail_count;

   serial_password_checker #(
      .DIGITS      (DIGITS),
      .DIGIT_W     (DIGIT_W),
      .MAX_FAIL    (MAX_FAIL),
      .USER_INIT   (USER_INIT),
      .ADMIN_CODE  (ADMIN_CODE),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .enable         (enable),
      .digit          (digit),
      .clear          (clear),
      .set_mode       (set_mode),
      .reset_lockdown (reset_lockdown),
      .position       (position),
      .error_light    (error_light),
      .unlock_light   (unlock_light),
      .prog_light     (prog_light),
      .lockdown       (lockdown),
      .fail_count     (fail_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: lock behaviour expressed as modes, digit queues and integer counters.
   typedef enum {M_ENTRY, M_OPEN, M_PROG, M_LOCKED} mmode_t;
   mmode_t m_mode;
   int     m_pw[DIGITS];
   int     m_admin[DIGITS];
   int     m_entered[$];
   int     m_newpw[$];
   int     m_fails;
   bit     m_err;
   int     m_edge;
   int     m_lock_edge;

   function automatic bit entered_is(input int code[DIGITS]);
      if (m_entered.size() != DIGITS) return 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (m_entered[i] != code[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_mode = M_ENTRY;
      m_entered.delete();
      m_newpw.delete();
      m_fails = 0;
      m_err   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         m_pw[i]    = int'((USER_INIT >> (4 * i)) & 16'hF);
         m_admin[i] = int'((ADMIN_CODE >> (4 * i)) & 16'hF);
      end
   endtask

   task automatic model_edge(input bit en, input int d, input bit clr, input bit sm, input bit rl);
      bit timed_out;
      m_edge++;
      m_err     = 1'b0;
      timed_out = 1'b0;
`ifdef LOCK_TIMEOUT_EN
      timed_out = (m_mode == M_LOCKED) && (m_edge - m_lock_edge == LOCK_CYCLES);
`endif
      case (m_mode)
         M_ENTRY: begin
            if (rl) m_fails = 0;
            if (clr) m_entered.delete();
            else if (en) begin
               m_entered.push_back(d);
               if (m_entered.size() == DIGITS) begin
                  if (entered_is(m_admin) || entered_is(m_pw)) begin
                     m_mode  = M_OPEN;
                     m_fails = 0;
                  end else begin
                     m_fails++;
                     m_err = 1'b1;
                     if (m_fails == MAX_FAIL) begin
                        m_mode      = M_LOCKED;
                        m_lock_edge = m_edge;
                     end
                  end
                  m_entered.delete();
               end
            end
         end
         M_OPEN: begin
            if (rl) m_fails = 0;
            if (clr) m_mode = M_ENTRY;
            else if (sm) begin
               m_mode = M_PROG;
               m_newpw.delete();
            end
         end
         M_PROG: begin
            if (rl) m_fails = 0;
            if (clr) begin
               m_newpw.delete();
               m_mode = M_ENTRY;
            end else if (en) begin
               m_newpw.push_back(d);
               if (m_newpw.size() == DIGITS) begin
                  for (int i = 0; i < DIGITS; i++) m_pw[i] = m_newpw[i];
                  m_newpw.delete();
                  m_mode = M_ENTRY;
               end
            end
         end
         M_LOCKED: begin
            if (rl || timed_out) begin
               m_mode  = M_ENTRY;
               m_fails = 0;
               m_entered.delete();
            end else if (clr) m_entered.delete();
            else if (en) begin
               m_entered.push_back(d);
               if (m_entered.size() == DIGITS) begin
                  if (entered_is(m_admin)) begin
                     m_mode  = M_OPEN;
                     m_fails = 0;
                  end
                  m_entered.delete();
               end
            end
         end
         default: m_mode = M_ENTRY;
      endcase
   endtask

   task automatic compare_all();
      int exp_pos;
      exp_pos = (m_mode == M_PROG) ? m_newpw.size() :
                (m_mode == M_OPEN) ? 0 : m_entered.size();
      chk("position",     int'(position),     exp_pos);
      chk("error_light",  int'(error_light),  int'(m_err));
      chk("unlock_light", int'(unlock_light), int'(m_mode == M_OPEN));
      chk("prog_light",   int'(prog_light),   int'(m_mode == M_PROG));
      chk("lockdown",     int'(lockdown),     int'(m_mode == M_LOCKED));
      chk("fail_count",   int'(fail_count),   m_fails);
   endtask

   // Inputs change at the falling edge; outputs are compared at the next falling edge.
   task automatic step(input bit en, input int d, input bit clr = 0, input bit sm = 0,
                       input bit rl = 0);
      enable         = en;
      digit          = 4'(d);
      clear          = clr;
      set_mode       = sm;
      reset_lockdown = rl;
      @(posedge CLK);
      model_edge(en, d, clr, sm, rl);
      @(negedge CLK);
      compare_all();
      enable         = 1'b0;
      clear          = 1'b0;
      set_mode       = 1'b0;
      reset_lockdown = 1'b0;
   endtask

   task automatic enter(input int a, input int b, input int c, input int e);
      step(1, a);
      step(1, b);
      step(1, c);
      step(1, e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_position"}, int'(position), 0);
      chk({tag, "_error"},    int'(error_light), 0);
      chk({tag, "_unlock"},   int'(unlock_light), 0);
      chk({tag, "_prog"},     int'(prog_light), 0);
      chk({tag, "_lockdown"}, int'(lockdown), 0);
      chk({tag, "_fails"},    int'(fail_count), 0);
   endtask

   initial begin
      RST = 1'b0; enable = 1'b0; digit = '0; clear = 1'b0;
      set_mode = 1'b0; reset_lockdown = 1'b0;
      m_edge = 0; m_lock_edge = 0;
      model_reset();
      @(negedge CLK);
      chk_all_zero("reset");
      RST = 1'b1;

      // User password 1234 unlocks.
      enter(1, 2, 3, 4);
      chk("user_unlock", int'(unlock_light), 1);
      chk("user_unlock_fails", int'(fail_count), 0);
      step(0, 0, 1);

      // Three wrong attempts lock the device.
      enter(1, 2, 3, 5);
      chk("fail1_error", int'(error_light), 1);
      chk("fail1_count", int'(fail_count), 1);
      idle(1);
      chk("fail1_pulse_end", int'(error_light), 0);
      enter(1, 2, 3, 5);
      enter(1, 2, 3, 5);
      chk("fail3_lockdown", int'(lockdown), 1);
      chk("fail3_count", int'(fail_count), 3);
      enter(1, 2, 3, 4);
      chk("locked_user_ignored", int'(lockdown), 1);
      chk("locked_no_unlock", int'(unlock_light), 0);

      // Admin code releases lockdown.
      enter(9, 9, 9, 9);
      chk("admin_unlock", int'(unlock_light), 1);
      chk("admin_lock_clr", int'(lockdown), 0);
      chk("admin_fails", int'(fail_count), 0);

      // Program 5678.
      step(0, 0, 0, 1);
      chk("prog_enter", int'(prog_light), 1);
      step(1, 5); step(1, 6); step(1, 7);
      chk("prog_pos3", int'(position), 3);
      step(1, 8);
      chk("prog_done", int'(prog_light), 0);
      enter(1, 2, 3, 4);
      chk("old_pw_error", int'(error_light), 1);
      enter(5, 6, 7, 8);
      chk("new_pw_unlock", int'(unlock_light), 1);

      // Aborted programming keeps 5678.
      step(0, 0, 0, 1);
      step(1, 1); step(1, 2);
      step(0, 0, 1);
      chk("abort_prog_off", int'(prog_light), 0);
      enter(5, 6, 7, 8);
      chk("abort_keeps_pw", int'(unlock_light), 1);
      step(0, 0, 1, 1);
      chk("clear_over_setmode", int'(prog_light), 0);

      // Mid-entry clear keeps the fail count; enable+clear drops the digit.
      enter(1, 1, 1, 1);
      step(1, 1); step(1, 2);
      chk("mid_pos2", int'(position), 2);
      step(0, 0, 1);
      chk("mid_clear_pos", int'(position), 0);
      chk("mid_clear_fails", int'(fail_count), 1);
      step(1, 5, 1);
      chk("en_clr_pos", int'(position), 0);

      // Digit accepted during the error pulse.
      enter(0, 0, 0, 0);
      step(1, 5);
      chk("digit_in_err_pos", int'(position), 1);
      step(1, 6); step(1, 7); step(1, 8);
      chk("err_then_unlock", int'(unlock_light), 1);
      step(0, 0, 1);

      // reset_lockdown outside lockdown clears only the count.
      enter(0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("rl_idle_fails", int'(fail_count), 0);

      // Lock again and test release paths.
      enter(0, 0, 0, 0); enter(0, 0, 0, 0); enter(0, 0, 0, 0);
      chk("relock", int'(lockdown), 1);
      idle(LOCK_CYCLES + 2);
`ifdef LOCK_TIMEOUT_EN
      chk("timeout_release", int'(lockdown), 0);
`else
      chk("no_timeout_hold", int'(lockdown), 1);
`endif
      step(0, 0, 0, 0, 1);
      chk("rl_release", int'(lockdown), 0);
      chk("rl_release_fails", int'(fail_count), 0);

      // Asynchronous reset mid-entry restores USER_INIT.
      step(1, 1); step(1, 2);
      #2 RST = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_reset();
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
      RST = 1'b1;
      enter(1, 2, 3, 4);
      chk("init_pw_restored", int'(unlock_light), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
